// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the arbiter.
// slave = the arbiter's view, master = the CPU stages plus memory model.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  // Data-memory port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // Memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection for the arbiter: data has priority unless fetch has
// been passed over STARVE_MAX times in a row while it was waiting.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       i_forced;

  // Pick the winner and work out the next starvation count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    gnt_i_o  = 1'b0;
    gnt_d_o  = 1'b0;
    starve_d = starve_q;
    i_forced = i_req_i && (starve_q == STARVE_LIM);
    // Grants are suppressed while reset is held so none can leak out.
    if (idle_i && !rst) begin
      gnt_d_o = d_req_i && !i_forced;
      gnt_i_o = i_req_i && !gnt_d_o;
      if (!i_req_i || gnt_i_o) begin
        starve_d = '0;
      end else if (gnt_d_o && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and data ports,
// one outstanding transaction at a time, with a response timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;

  logic gnt_i, gnt_d;
  logic tmo_expired, rsp_fire;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .idle_i  (state_q == IDLE),
    .i_req_i (bus.i_req),
    .d_req_i (bus.d_req),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  // Next-state logic: latch the winner's fields, then walk REQ -> WAIT -> IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    tmo_expired = (state_q == WAIT) && !bus.m_rvalid && (tmo_q == TMO_LAST);
    rsp_fire    = (state_q == WAIT) && (bus.m_rvalid || tmo_expired);
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          owner_d   = OWN_D;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_we ? bus.d_wdata : '0;
          m_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
          state_d   = REQ;
        end else if (gnt_i) begin
          owner_d   = OWN_I;
          m_we_d    = 1'b0;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          m_wstrb_d = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.m_ready) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rsp_fire) state_d = IDLE;
        else          tmo_d   = tmo_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, timeout counter and the registered memory request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      tmo_q     <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tmo_q     <= tmo_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  assign bus.i_gnt   = gnt_i;
  assign bus.d_gnt   = gnt_d;

  assign bus.m_req   = (state_q == REQ);
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wstrb = m_wstrb_q;

  // Responses pass straight through from memory to the owning port only.
  assign bus.i_rvalid = rsp_fire && (owner_q == OWN_I);
  assign bus.d_rvalid = rsp_fire && (owner_q == OWN_D);
  assign bus.i_err    = bus.i_rvalid && tmo_expired;
  assign bus.d_err    = bus.d_rvalid && tmo_expired;
  assign bus.i_rdata  = (bus.i_rvalid && bus.m_rvalid) ? bus.m_rdata : '0;
  assign bus.d_rdata  = (bus.d_rvalid && bus.m_rvalid && !m_we_q) ? bus.m_rdata : '0;

endmodule
